// File: rtl/usb_tx_sequencer.sv
// USB transmit sequencer: emits the SYNC pattern, streams packet bytes LSB first
// to a bit stuffer, and closes each packet with an SE0/SE0/J end-of-packet.
module usb_tx_sequencer (
    input  logic       clk,
    input  logic       RST,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       bit_tick,
    input  logic       stf_ready,
    output logic       stf_bit,
    output logic       stf_en,
    output logic       eop_se0,
    output logic       eop_j,
    output logic       busy,
    output logic       err_underrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        EOP  = 2'd3
    } state_t;

    state_t     state_reg;
    logic [7:0] shreg_reg;
    logic [2:0] bit_cnt_reg;
    logic [1:0] eop_cnt_reg;
    logic       last_reg;

    logic qtick;
    logic shifting;
    logic last_bit;
    logic load_slot;

    // A tick only counts when the stuffer is not busy inserting a stuff bit.
    assign qtick     = bit_tick & stf_ready;
    assign shifting  = (state_reg == SYNC) || (state_reg == DATA);
    assign last_bit  = shifting && qtick && (bit_cnt_reg == 3'd7);
    assign load_slot = last_bit && ((state_reg == SYNC) || !last_reg);

    assign tx_ready     = load_slot;
    assign err_underrun = load_slot & ~tx_valid;
    assign stf_en       = shifting & qtick;
    assign stf_bit      = shifting & shreg_reg[0];
    assign eop_se0      = (state_reg == EOP) && (eop_cnt_reg != 2'd2);
    assign eop_j        = (state_reg == EOP) && (eop_cnt_reg == 2'd2);
    assign busy         = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (RST) begin
            state_reg   <= IDLE;
            shreg_reg   <= 8'h00;
            bit_cnt_reg <= 3'd0;
            eop_cnt_reg <= 2'd0;
            last_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (tx_valid) begin
                        state_reg   <= SYNC;
                        shreg_reg   <= 8'h80;
                        bit_cnt_reg <= 3'd0;
                        last_reg    <= 1'b0;
                    end
                end
                SYNC, DATA: begin
                    if (qtick) begin
                        shreg_reg   <= shreg_reg >> 1;
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (load_slot) begin
                            if (tx_valid) begin
                                shreg_reg   <= tx_data;
                                last_reg    <= tx_last;
                                bit_cnt_reg <= 3'd0;
                                state_reg   <= DATA;
                            end else begin
                                // Byte missing mid-packet: abort straight into EOP.
                                state_reg   <= EOP;
                                eop_cnt_reg <= 2'd0;
                            end
                        end else if (last_bit) begin
                            state_reg   <= EOP;
                            eop_cnt_reg <= 2'd0;
                        end
                    end
                end
                EOP: begin
                    // EOP timing follows raw bit_tick; the stuffer is idle here.
                    if (bit_tick) begin
                        if (eop_cnt_reg == 2'd2) begin
                            state_reg   <= IDLE;
                            eop_cnt_reg <= 2'd0;
                        end else begin
                            eop_cnt_reg <= eop_cnt_reg + 2'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Scoreboard bench for usb_tx_sequencer: a packet-level model queues the expected
// line events; a monitor pops and compares them as the DUT produces them.
module tb_usb_tx_sequencer;

    logic       clk = 1'b0;
    logic       RST;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       bit_tick;
    logic       stf_ready;
    logic       stf_bit;
    logic       stf_en;
    logic       eop_se0;
    logic       eop_j;
    logic       busy;
    logic       err_underrun;

    always #5 clk = ~clk;

    usb_tx_sequencer dut (
        .clk          (clk),
        .RST          (RST),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_last      (tx_last),
        .tx_ready     (tx_ready),
        .bit_tick     (bit_tick),
        .stf_ready    (stf_ready),
        .stf_bit      (stf_bit),
        .stf_en       (stf_en),
        .eop_se0      (eop_se0),
        .eop_j        (eop_j),
        .busy         (busy),
        .err_underrun (err_underrun)
    );

    // Event codes: 0/1 = stuffed bit value, 2 = SE0 bit time, 3 = J bit time, 4 = underrun pulse.
    int exp_q[$];
    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int gaps[$];
    int idle_run = 0;
    bit prev_busy = 1'b0;
    bit se0_seen  = 1'b0;

    int tick_period = 4;
    bit rand_stall  = 1'b0;
    int stall_at    = -1;
    bit stall_done  = 1'b0;

    int b_q[$];
    int l_q[$];

    function automatic void check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    function automatic void expect_event(input string name, input int code);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: got event %0d expected no event", name, code);
        end else begin
            check(name, code, exp_q.pop_front());
        end
    endfunction

    // Bit-time strobe and stuffer-ready generator.
    initial begin
        int ph;
        ph = 0;
        bit_tick  = 1'b0;
        stf_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bit_tick = (ph == 0);
            ph = (ph + 1 >= tick_period) ? 0 : ph + 1;
            stf_ready = 1'b1;
            if (rand_stall && $urandom_range(0, 3) == 0) stf_ready = 1'b0;
            if (bit_tick && stall_at >= 0 && !stall_done && pulses == stall_at) begin
                stf_ready  = 1'b0;
                stall_done = 1'b1;
            end
        end
    end

    // Monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (!RST) begin
                if (stf_en) begin
                    pulses++;
                    expect_event("stf_bit", int'(stf_bit));
                    check("stf_en_needs_qtick", int'(bit_tick && stf_ready), 1);
                end
                if (bit_tick && !stf_ready) check("stf_en_on_stall", int'(stf_en), 0);
                if (tx_ready) check("tx_ready_on_qtick", int'(stf_en), 1);
                if (bit_tick && eop_se0) expect_event("eop_se0_tick", 2);
                if (bit_tick && eop_j) expect_event("eop_j_tick", 3);
                if (err_underrun) expect_event("err_underrun", 4);
                if (eop_se0 || eop_j) begin
                    check("eop_exclusive", int'(eop_se0 && eop_j), 0);
                    check("stf_en_in_eop", int'(stf_en), 0);
                end
                if (eop_se0) se0_seen = 1'b1;
                if (busy && !prev_busy) gaps.push_back(idle_run);
                if (busy) idle_run = 0;
                else idle_run++;
                prev_busy = busy;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_ready"}, int'(tx_ready), 0);
        check({tag, "_stf_en"}, int'(stf_en), 0);
        check({tag, "_stf_bit"}, int'(stf_bit), 0);
        check({tag, "_eop_se0"}, int'(eop_se0), 0);
        check({tag, "_eop_j"}, int'(eop_j), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_err_underrun"}, int'(err_underrun), 0);
    endtask

    // Drives a byte stream (tx_valid held while bytes remain); lasts[] splits it into packets.
    // under_k >= 0 withholds byte under_k; abort_at > 0 resets once that many bits went out.
    task automatic run_stream(input int bytes[$], input int lasts[$], input int under_k,
                              input int abort_at);
        int  eff;
        int  exp_pulses;
        int  idx;
        int  acc;
        int  cyc;
        bit  start;
        bit  take;
        bit  done;
        eff        = (under_k >= 0) ? under_k : bytes.size();
        exp_pulses = 0;
        start      = 1'b1;
        for (int i = 0; i < eff; i++) begin
            if (start) begin
                for (int b = 0; b < 8; b++) exp_q.push_back((b == 7) ? 1 : 0);
                exp_pulses += 8;
                start = 1'b0;
            end
            for (int b = 0; b < 8; b++) exp_q.push_back((bytes[i] >> b) & 1);
            exp_pulses += 8;
            if (lasts[i] != 0) begin
                exp_q.push_back(2);
                exp_q.push_back(2);
                exp_q.push_back(3);
                start = 1'b1;
            end
        end
        if (under_k >= 0) begin
            exp_q.push_back(4);
            exp_q.push_back(2);
            exp_q.push_back(2);
            exp_q.push_back(3);
        end

        pulses = 0;
        gaps.delete();
        idx  = 0;
        acc  = 0;
        cyc  = 0;
        done = 1'b0;
        @(posedge clk);
        #1;
        tx_valid = 1'b1;
        tx_data  = bytes[0][7:0];
        tx_last  = (lasts[0] != 0);
        while (!done) begin
            @(negedge clk);
            take = tx_ready && tx_valid;
            @(posedge clk);
            #1;
            cyc++;
            if (take) begin
                acc++;
                idx++;
                if (idx < eff) begin
                    tx_data = bytes[idx][7:0];
                    tx_last = (lasts[idx] != 0);
                end else begin
                    tx_valid = 1'b0;
                    tx_data  = 8'($urandom);
                    tx_last  = 1'($urandom);
                end
            end
            if (abort_at > 0 && pulses >= abort_at) begin
                RST      = 1'b1;
                tx_valid = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_all_zero("reset_mid_packet");
                exp_q.delete();
                se0_seen = 1'b0;
                @(posedge clk);
                #1;
                RST = 1'b0;
                repeat (40) @(posedge clk);
                #1;
                check("no_eop_after_abort", int'(se0_seen), 0);
                check("idle_after_abort", int'(busy), 0);
                return;
            end
            if (idx >= eff && exp_q.size() == 0 && !busy) done = 1'b1;
            if (cyc > 5000) begin
                checks++;
                failures++;
                $display("FAIL stream_timeout: got %0d events pending busy=%0d expected 0 pending busy=0",
                         exp_q.size(), busy);
                exp_q.delete();
                done = 1'b1;
            end
        end
        check("stf_en_count", pulses, exp_pulses);
        check("bytes_accepted", acc, eff);
        $display("stream bytes=%0d underrun_at=%0d pulses=%0d accepted=%0d period=%0d",
                 bytes.size(), under_k, pulses, acc, tick_period);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int npk;
        int len;
        int uk;
        RST      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tx_last  = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        RST      = 1'b0;
        repeat (3) @(posedge clk);

        // 1-byte packet A5
        b_q = '{32'hA5};
        l_q = '{1};
        run_stream(b_q, l_q, -1, 0);

        // Stuffer stall on data bit 3
        stall_done = 1'b0;
        stall_at   = 11;
        run_stream(b_q, l_q, -1, 0);
        stall_at = -1;

        // 2-byte packet FF, 01
        b_q = '{32'hFF, 32'h01};
        l_q = '{0, 1};
        run_stream(b_q, l_q, -1, 0);

        // Underrun on the second byte
        run_stream(b_q, l_q, 1, 0);

        // Reset during data bit 4
        b_q = '{32'hA5};
        l_q = '{1};
        run_stream(b_q, l_q, -1, 12);

        // tx_valid held through EOP: next SYNC after a single IDLE cycle
        b_q = '{32'h3C, 32'h3C};
        l_q = '{1, 1};
        run_stream(b_q, l_q, -1, 0);
        check("gap_count", gaps.size(), 2);
        if (gaps.size() > 0) check("idle_gap_cycles", gaps[gaps.size() - 1], 1);

        // Randomized streams
        for (int it = 0; it < 16; it++) begin
            tick_period = $urandom_range(1, 5);
            rand_stall  = 1'($urandom_range(0, 1));
            b_q.delete();
            l_q.delete();
            npk = $urandom_range(1, 2);
            for (int p = 0; p < npk; p++) begin
                len = $urandom_range(1, 3);
                for (int i = 0; i < len; i++) begin
                    b_q.push_back($urandom_range(0, 255));
                    l_q.push_back((i == len - 1) ? 1 : 0);
                end
            end
            uk = -1;
            if (npk == 1 && b_q.size() >= 2 && $urandom_range(0, 3) == 0)
                uk = $urandom_range(1, b_q.size() - 1);
            run_stream(b_q, l_q, uk, 0);
        end
        rand_stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
